bus_master_seq: RTL

- Parametrised, FIFO-fed bus master for the arbitrator test system.
- Accepts queued commands (read/write, target slave, burst length, pre-request gap) and requests the shared bus, advertising the remaining beats on req.
- Transfers one beat per granted cycle and generates per-slave write data; checks read data against per-slave expected counters.
- Flags grant timeouts and read mismatches as status outputs instead of simulation-only messages.

---
 rtl/bus_master_seq.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/bus_master_seq.sv
// FIFO-fed bus master: queues commands, requests the shared bus, generates write data and checks read data.
// Define BUS_MASTER_SEQ_PARK_EN to let a gap-0 head command follow the last beat without an IDLE bubble.
module bus_master_seq #(
  parameter int          ID      = 0,
  parameter int          DW      = 32,
  parameter int          AW      = 32,
  parameter int          NSLV    = 4,
  parameter int          DEPTH   = 4,
  parameter int          LENW    = 4,
  parameter int          GAPW    = 5,
  parameter int          TIMEOUT = 60,
  parameter logic [31:0] BASE    = 32'hFFEF_0200,
  localparam int         SW      = $clog2(NSLV)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_rw,
  input  logic [SW-1:0]   cmd_slv,
  input  logic [LENW-1:0] cmd_len,
  input  logic [GAPW-1:0] cmd_gap,
  output logic [LENW-1:0] req,
  output logic            xfr,
  output logic            RW,
  output logic [AW-1:0]   addr,
  output logic [DW-1:0]   DataToSlave,
  input  logic            grant,
  input  logic [DW-1:0]   DataFromSlave,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic            rd_err,
  output logic [15:0]     err_cnt
);

  localparam int CW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ARB} state_t;

  state_t          state_q;
  logic            fifo_rw_q  [DEPTH];
  logic [SW-1:0]   fifo_slv_q [DEPTH];
  logic [LENW-1:0] fifo_len_q [DEPTH];
  logic [GAPW-1:0] fifo_gap_q [DEPTH];
  logic [CW-1:0]   wp_q, rp_q;
  logic [CW:0]     cnt_q;

  logic            rw_q;
  logic [SW-1:0]   slv_q;
  logic [LENW-1:0] beats_q;
  logic [GAPW-1:0] gap_q;
  logic [TW-1:0]   timer_q;
  logic [DW-1:0]   wr_cnt_q [NSLV];
  logic [DW-1:0]   wr_cnt_d [NSLV];
  logic [DW-1:0]   rd_exp_q [NSLV];
  logic [DW-1:0]   rd_exp_d [NSLV];

  logic            xfr_q, bus_rw_q, done_q, timeout_q, rd_err_q;
  logic [LENW-1:0] req_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [15:0]     err_cnt_q;

  logic            empty, full, push, pop, beat_ok, last_beat, park_pop, mism, to_evt;
  logic            hd_rw;
  logic [SW-1:0]   hd_slv;
  logic [LENW-1:0] hd_len;
  logic [GAPW-1:0] hd_gap;

  function automatic logic [AW-1:0] addr_of(input logic [SW-1:0] s);
    return AW'(BASE) | (AW'(s) << 12) | (AW'(ID) << 4);
  endfunction

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == (CW+1)'(DEPTH));
  assign cmd_ready = !full;
  assign busy      = (state_q != S_IDLE) || !empty;
  assign hd_rw     = fifo_rw_q[rp_q];
  assign hd_slv    = fifo_slv_q[rp_q];
  assign hd_len    = fifo_len_q[rp_q];
  assign hd_gap    = fifo_gap_q[rp_q];

  assign push      = cmd_valid && !full;
  assign beat_ok   = (state_q == S_ARB) && grant;
  assign last_beat = beat_ok && (beats_q == '0);
`ifdef BUS_MASTER_SEQ_PARK_EN
  assign park_pop  = last_beat && !empty && (hd_gap == '0);
`else
  assign park_pop  = 1'b0;
`endif
  assign pop       = ((state_q == S_IDLE) && !empty) || park_pop;
  assign mism      = beat_ok && !rw_q && (DataFromSlave != rd_exp_q[slv_q]);
  assign to_evt    = (state_q == S_ARB) && !grant && (timer_q == '0);

  // Counters advance here so the next beat's data (even for a parked command) sees the update.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_exp_d = rd_exp_q;
    if (beat_ok) begin
      if (rw_q) wr_cnt_d[slv_q] = wr_cnt_q[slv_q] + DW'(1);
      else      rd_exp_d[slv_q] = rd_exp_q[slv_q] + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      slv_q     <= '0;
      beats_q   <= '0;
      gap_q     <= '0;
      timer_q   <= '0;
      xfr_q     <= 1'b0;
      bus_rw_q  <= 1'b0;
      req_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      rd_err_q  <= 1'b0;
      err_cnt_q <= '0;
      for (int s = 0; s < NSLV; s++) begin
        wr_cnt_q[s] <= DW'(s) << (DW - 4);
        rd_exp_q[s] <= DW'(s) << (DW - 8);
      end
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      rd_err_q  <= mism;
      wr_cnt_q  <= wr_cnt_d;
      rd_exp_q  <= rd_exp_d;
      if ((mism || to_evt) && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;

      if (push) begin
        fifo_rw_q[wp_q]  <= cmd_rw;
        fifo_slv_q[wp_q] <= cmd_slv;
        fifo_len_q[wp_q] <= cmd_len;
        fifo_gap_q[wp_q] <= cmd_gap;
        wp_q             <= wp_q + CW'(1);
      end
      if (pop) rp_q <= rp_q + CW'(1);
      cnt_q <= cnt_q + (CW+1)'(push) - (CW+1)'(pop);

      case (state_q)
        S_IDLE: if (!empty) begin
          rw_q    <= hd_rw;
          slv_q   <= hd_slv;
          beats_q <= hd_len;
          gap_q   <= hd_gap;
          timer_q <= TW'(TIMEOUT);
          if (hd_gap != '0) begin
            state_q <= S_WAIT;
          end else begin
            state_q  <= S_ARB;
            xfr_q    <= 1'b1;
            req_q    <= hd_len;
            bus_rw_q <= hd_rw;
            addr_q   <= addr_of(hd_slv);
            wdata_q  <= hd_rw ? wr_cnt_d[hd_slv] : '0;
          end
        end
        S_WAIT: begin
          if (gap_q == GAPW'(1)) begin
            state_q  <= S_ARB;
            xfr_q    <= 1'b1;
            req_q    <= beats_q;
            bus_rw_q <= rw_q;
            addr_q   <= addr_of(slv_q);
            wdata_q  <= rw_q ? wr_cnt_d[slv_q] : '0;
          end
          gap_q <= gap_q - GAPW'(1);
        end
        S_ARB: begin
          if (grant) begin
            timer_q <= TW'(TIMEOUT);
            if (beats_q == '0) begin
              done_q <= 1'b1;
              if (park_pop) begin
                rw_q     <= hd_rw;
                slv_q    <= hd_slv;
                beats_q  <= hd_len;
                req_q    <= hd_len;
                bus_rw_q <= hd_rw;
                addr_q   <= addr_of(hd_slv);
                wdata_q  <= hd_rw ? wr_cnt_d[hd_slv] : '0;
              end else begin
                state_q  <= S_IDLE;
                xfr_q    <= 1'b0;
                req_q    <= '0;
                bus_rw_q <= 1'b0;
                addr_q   <= '0;
                wdata_q  <= '0;
              end
            end else begin
              beats_q <= beats_q - LENW'(1);
              req_q   <= beats_q - LENW'(1);
              wdata_q <= rw_q ? wr_cnt_d[slv_q] : '0;
            end
          end else if (timer_q == '0) begin
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
            xfr_q     <= 1'b0;
            req_q     <= '0;
            bus_rw_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign xfr         = xfr_q;
  assign req         = req_q;
  assign RW          = bus_rw_q;
  assign addr        = addr_q;
  assign DataToSlave = wdata_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign rd_err      = rd_err_q;
  assign err_cnt     = err_cnt_q;

endmodule
